// File: rtl/ps2_rx_frontend.sv
// ps2_rx_frontend: PS/2 pin conditioning, 11-bit frame receiver and scan-code FIFO
module ps2_rx_frontend #(
  parameter int FILT_LEN    = 8,
  parameter int TIMEOUT_CYC = 100000,
  parameter int FIFO_DEPTH  = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic [7:0] code_data,
  output logic       code_valid,
  input  logic       code_ready,
  output logic       parity_err,
  output logic       frame_err,
  output logic       overflow,
  input  logic       clr_overflow,
  output logic       busy
);
  localparam int FW = $clog2(FILT_LEN + 1);
  localparam int TW = $clog2(TIMEOUT_CYC);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [1:0] IDLE = 2'd0, DATA = 2'd1, PARITY = 2'd2, STOP = 2'd3;
  logic [1:0]         pin, filt_q;
  logic [1:0][1:0]    sync_q;
  logic [1:0][FW-1:0] fcnt_q;
  logic               fclk_prev_q, strobe, din;
  logic [1:0]         state_q, state_d;
  logic [2:0]         bit_cnt_q, bit_cnt_d;
  logic [7:0]         shift_q, shift_d;
  logic               par_q, par_d, perr_q, perr_d, ferr_q, ferr_d, push, ovf_q;
  logic [TW-1:0]      tcnt_q, tcnt_d;
  logic [7:0]         mem_q [FIFO_DEPTH];
  logic [AW-1:0]      wr_ptr_q, rd_ptr_q;
  logic [AW:0]        count_q;
  logic               full, empty, pop, wr;
  assign pin = {ps2_data, ps2_clk};
  // Index 0 is the clock pin, index 1 the data pin
  always_ff @(posedge clk)
    if (reset) begin
      sync_q      <= '1;
      fcnt_q      <= '0;
      filt_q      <= 2'b11;
      fclk_prev_q <= 1'b1;
    end else begin
      fclk_prev_q <= filt_q[0];
      for (int i = 0; i < 2; i++) begin
        sync_q[i] <= {sync_q[i][0], pin[i]};
        if (sync_q[i][1] == filt_q[i]) fcnt_q[i] <= '0;
        else if (fcnt_q[i] == FW'(FILT_LEN - 1)) begin
          filt_q[i] <= sync_q[i][1];
          fcnt_q[i] <= '0;
        end else fcnt_q[i] <= fcnt_q[i] + FW'(1);
      end
    end
  assign strobe = fclk_prev_q & ~filt_q[0];
  assign din    = filt_q[1];
  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    shift_d   = shift_q;
    par_d     = par_q;
    tcnt_d    = (state_q == IDLE || strobe) ? '0 : tcnt_q + TW'(1);
    push      = 1'b0;
    perr_d    = 1'b0;
    ferr_d    = 1'b0;
    if (state_q != IDLE && !strobe && tcnt_q == TW'(TIMEOUT_CYC - 1)) begin
      state_d = IDLE;
      ferr_d  = 1'b1;
      tcnt_d  = '0;
    end else if (strobe)
      case (state_q)
        IDLE: begin
          state_d   = din ? IDLE : DATA;
          bit_cnt_d = '0;
        end
        DATA: begin
          shift_d   = {din, shift_q[7:1]};
          bit_cnt_d = bit_cnt_q + 3'd1;
          state_d   = (bit_cnt_q == 3'd7) ? PARITY : DATA;
        end
        PARITY: begin
          par_d   = din;
          state_d = STOP;
        end
        default: begin
          state_d = IDLE;
          push    = din & ^{shift_q, par_q};
          perr_d  = din & ~^{shift_q, par_q};
          ferr_d  = ~din;
        end
      endcase
  end
  assign full  = count_q == (AW+1)'(FIFO_DEPTH);
  assign empty = count_q == '0;
  assign pop   = ~empty & code_ready;
  assign wr    = push & (~full | pop);
  always_ff @(posedge clk)
    if (reset) begin
      state_q   <= IDLE;
      bit_cnt_q <= '0;
      shift_q   <= '0;
      par_q     <= 1'b0;
      tcnt_q    <= '0;
      perr_q    <= 1'b0;
      ferr_q    <= 1'b0;
      ovf_q     <= 1'b0;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      mem_q     <= '{default: '0};
    end else begin
      state_q   <= state_d;
      bit_cnt_q <= bit_cnt_d;
      shift_q   <= shift_d;
      par_q     <= par_d;
      tcnt_q    <= tcnt_d;
      perr_q    <= perr_d;
      ferr_q    <= ferr_d;
      ovf_q     <= clr_overflow ? 1'b0 : (push & full & ~pop) ? 1'b1 : ovf_q;
      if (wr) begin
        mem_q[wr_ptr_q] <= shift_q;
        wr_ptr_q        <= wr_ptr_q + AW'(1);
      end
      if (pop) rd_ptr_q <= rd_ptr_q + AW'(1);
      count_q <= count_q + (AW+1)'(wr) - (AW+1)'(pop);
    end
  // When empty, show the entry just popped so the last head value is held
  assign code_data  = mem_q[empty ? rd_ptr_q - AW'(1) : rd_ptr_q];
  assign code_valid = ~empty;
  assign parity_err = perr_q;
  assign frame_err  = ferr_q;
  assign overflow   = ovf_q;
  assign busy       = state_q != IDLE;
endmodule

// File: tb/tb_ps2_rx_frontend.sv
// tb_ps2_rx_frontend: drives PS/2 frames and checks bytes, error pulses and FIFO against a queue model
module tb_ps2_rx_frontend;
  localparam int HALF = 40;
  localparam int TO   = 1000;
  logic clk = 1'b0, reset = 1'b1, ps2_clk = 1'b1, ps2_data = 1'b1;
  logic code_ready = 1'b0, clr_overflow = 1'b0;
  logic [7:0] code_data;
  logic code_valid, parity_err, frame_err, overflow, busy;
  int errors = 0, checks = 0, perr_n = 0, ferr_n = 0;
  logic [7:0] exp_q[$];
  logic ovf_m = 1'b0;
  always #5 clk = ~clk;
  ps2_rx_frontend #(.FILT_LEN(8), .TIMEOUT_CYC(TO), .FIFO_DEPTH(4)) dut (
    .clk(clk), .reset(reset), .ps2_clk(ps2_clk), .ps2_data(ps2_data),
    .code_data(code_data), .code_valid(code_valid), .code_ready(code_ready),
    .parity_err(parity_err), .frame_err(frame_err), .overflow(overflow),
    .clr_overflow(clr_overflow), .busy(busy));
  always @(negedge clk) begin
    if (parity_err === 1'b1) perr_n++;
    if (frame_err === 1'b1) ferr_n++;
  end
  function automatic logic [10:0] frame(input logic [7:0] d, input logic bad_par, input logic bad_stop);
    return {~bad_stop, ~^d ^ bad_par, d, 1'b0};
  endfunction
  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask
  task automatic send_bit(input logic b);
    ps2_data = b;
    cyc(HALF / 2);
    ps2_clk = 1'b0;
    cyc(HALF);
    ps2_clk = 1'b1;
    cyc(HALF / 2);
  endtask
  task automatic model_frame(input logic [10:0] f, output int pe, output int fe);
    fe = f[10] ? 0 : 1;
    pe = (f[10] && !(^f[9:1])) ? 1 : 0;
    if (f[10] && ^f[9:1]) begin
      if (exp_q.size() < 4) exp_q.push_back(f[8:1]);
      else ovf_m = 1'b1;
    end
  endtask
  task automatic check_frame(input string name, input logic [10:0] f);
    int p0, f0, pe, fe;
    p0 = perr_n;
    f0 = ferr_n;
    model_frame(f, pe, fe);
    for (int i = 0; i < 11; i++) send_bit(f[i]);
    cyc(HALF);
    checks++;
    if (perr_n - p0 != pe || ferr_n - f0 != fe)
      $display("FAIL %s pulses: parity=%0d frame=%0d, expected parity=%0d frame=%0d", name, perr_n - p0, ferr_n - f0, pe, fe);
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL %s busy after frame: got %b expected 0", name, busy); end
    if (perr_n - p0 != pe || ferr_n - f0 != fe) errors++;
  endtask
  task automatic drain(input string name);
    while (exp_q.size() > 0) begin
      @(negedge clk);
      checks++;
      if (code_valid !== 1'b1 || code_data !== exp_q[0]) begin
        errors++;
        $display("FAIL %s drain: valid=%b data=%h expected valid=1 data=%h", name, code_valid, code_data, exp_q[0]);
      end
      void'(exp_q.pop_front());
      code_ready = 1'b1;
      @(posedge clk);
      #1 code_ready = 1'b0;
    end
    @(negedge clk);
    checks++;
    if (code_valid !== 1'b0) begin errors++; $display("FAIL %s empty after drain: valid=%b expected 0", name, code_valid); end
  endtask
  task automatic test_reset();
    reset = 1'b1;
    cyc(3);
    @(negedge clk);
    checks += 6;
    if (code_valid !== 1'b0) begin errors++; $display("FAIL reset code_valid: got %b expected 0", code_valid); end
    if (code_data !== 8'h00) begin errors++; $display("FAIL reset code_data: got %h expected 00", code_data); end
    if (busy !== 1'b0) begin errors++; $display("FAIL reset busy: got %b expected 0", busy); end
    if (overflow !== 1'b0) begin errors++; $display("FAIL reset overflow: got %b expected 0", overflow); end
    if (parity_err !== 1'b0) begin errors++; $display("FAIL reset parity_err: got %b expected 0", parity_err); end
    if (frame_err !== 1'b0) begin errors++; $display("FAIL reset frame_err: got %b expected 0", frame_err); end
    @(posedge clk);
    #1 reset = 1'b0;
    cyc(HALF);
  endtask
  task automatic test_good_frame();
    logic [10:0] f;
    int p0, f0, pe, fe;
    bit found;
    f = frame(8'h1C, 1'b0, 1'b0);
    p0 = perr_n;
    f0 = ferr_n;
    model_frame(f, pe, fe);
    for (int i = 0; i < 10; i++) send_bit(f[i]);
    ps2_data = f[10];
    cyc(HALF / 2);
    ps2_clk = 1'b0;
    found = 0;
    for (int i = 0; i < 200 && !found; i++) begin
      @(negedge clk);
      if (dut.strobe === 1'b1) found = 1;
    end
    checks++;
    if (!found || code_valid !== 1'b0) begin errors++; $display("FAIL latency strobe cycle: strobe_seen=%0d valid=%b expected 1,0", found, code_valid); end
    @(negedge clk);
    checks++;
    if (code_valid !== 1'b1 || code_data !== 8'h1C) begin errors++; $display("FAIL latency next cycle: valid=%b data=%h expected 1,1c", code_valid, code_data); end
    cyc(HALF);
    ps2_clk = 1'b1;
    cyc(HALF);
    checks++;
    if (perr_n != p0 || ferr_n != f0) begin errors++; $display("FAIL good frame pulses: parity=%0d frame=%0d expected 0,0", perr_n - p0, ferr_n - f0); end
    drain("good_frame");
  endtask
  task automatic test_parity();
    check_frame("parity", frame(8'h1C, 1'b1, 1'b0));
    @(negedge clk);
    checks++;
    if (code_valid !== 1'b0) begin errors++; $display("FAIL parity code_valid: got %b expected 0", code_valid); end
  endtask
  task automatic test_timeout();
    int p0, f0;
    bit found;
    p0 = perr_n;
    f0 = ferr_n;
    send_bit(1'b0);
    for (int i = 0; i < 4; i++) send_bit(1'($urandom_range(0, 1)));
    checks++;
    if (busy !== 1'b1) begin errors++; $display("FAIL timeout busy mid-frame: got %b expected 1", busy); end
    found = 0;
    for (int i = 0; i < TO + 200 && !found; i++) begin
      @(negedge clk);
      if (ferr_n != f0) found = 1;
    end
    cyc(20);
    checks++;
    if (!found || ferr_n - f0 != 1 || perr_n != p0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL timeout: frame pulses=%0d parity pulses=%0d busy=%b expected 1,0,0", ferr_n - f0, perr_n - p0, busy);
    end
    check_frame("after_timeout", frame(8'hF0, 1'b0, 1'b0));
    drain("after_timeout");
  endtask
  task automatic test_overflow();
    for (int i = 1; i <= 5; i++) check_frame("overflow", frame(8'(i), 1'b0, 1'b0));
    @(negedge clk);
    checks++;
    if (overflow !== ovf_m || ovf_m !== 1'b1) begin errors++; $display("FAIL overflow flag: got %b expected 1", overflow); end
    drain("overflow");
    @(posedge clk);
    #1 clr_overflow = 1'b1;
    cyc(1);
    clr_overflow = 1'b0;
    ovf_m = 1'b0;
    @(negedge clk);
    checks++;
    if (overflow !== 1'b0) begin errors++; $display("FAIL overflow clear: got %b expected 0", overflow); end
  endtask
  task automatic test_glitch();
    int p0, f0;
    bit bad;
    p0 = perr_n;
    f0 = ferr_n;
    @(posedge clk);
    #1 ps2_clk = 1'b0;
    cyc(3);
    ps2_clk = 1'b1;
    bad = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (busy !== 1'b0) bad = 1;
    end
    checks++;
    if (bad || perr_n != p0 || ferr_n != f0) begin errors++; $display("FAIL glitch: busy_seen=%0d pulses=%0d expected 0,0", bad, perr_n - p0 + ferr_n - f0); end
  endtask
  task automatic test_reset_midframe();
    logic [10:0] f;
    check_frame("pre_reset", frame(8'h33, 1'b0, 1'b0));
    f = frame(8'h6B, 1'b0, 1'b0);
    for (int i = 0; i < 6; i++) send_bit(f[i]);
    checks++;
    if (busy !== 1'b1 || code_valid !== 1'b1) begin errors++; $display("FAIL midframe before reset: busy=%b valid=%b expected 1,1", busy, code_valid); end
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    checks++;
    if (busy !== 1'b0 || code_valid !== 1'b0 || code_data !== 8'h00 || overflow !== 1'b0) begin
      errors++;
      $display("FAIL midframe reset: busy=%b valid=%b data=%h ovf=%b expected 0,0,00,0", busy, code_valid, code_data, overflow);
    end
    exp_q.delete();
    ovf_m = 1'b0;
    @(posedge clk);
    #1 reset = 1'b0;
    ps2_data = 1'b1;
    cyc(HALF);
    check_frame("after_reset", frame(8'h5A, 1'b0, 1'b0));
    drain("after_reset");
  endtask
  task automatic test_random();
    for (int n = 0; n < 10; n++)
      check_frame("random", frame(8'($urandom), $urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0));
    @(negedge clk);
    checks++;
    if (overflow !== ovf_m) begin errors++; $display("FAIL random overflow: got %b expected %b", overflow, ovf_m); end
    drain("random");
  endtask
  initial begin
    test_reset();
    test_good_frame();
    test_parity();
    test_timeout();
    test_overflow();
    test_glitch();
    test_reset_midframe();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached, errors=%0d checks=%0d", errors, checks);
    $fatal(1);
  end
endmodule
